// File: rtl/axis_sub_stim_chk_if.sv
`default_nettype none
// ============================================================================
//  Module   : axis_sub_stim_chk_if
//  Purpose  : One AXI-Stream channel (data, last, valid, ready) with
//             master and slave views.
//  Revision : 1.0 - initial release
// ============================================================================
interface axis_sub_stim_chk_if #(
  parameter int DATA_W = 32
);
  logic [DATA_W-1:0] tdata;
  logic              tlast;
  logic              tvalid;
  logic              tready;

  modport master (output tdata, output tlast, output tvalid, input tready);
  modport slave  (input tdata, input tlast, input tvalid, output tready);
endinterface
`default_nettype wire

// File: rtl/axis_sub_stim_chk.sv
`default_nettype none
// ============================================================================
//  Module   : axis_sub_stim_chk
//  Purpose  : Traffic end for an AXIS subtracter. Sources framed operand
//             streams a (ramp) and b (constant), then checks every result
//             beat against (a - b) and the expected tlast position.
//  Revision : 1.0 - initial release
// ============================================================================
module axis_sub_stim_chk #(
  parameter int                DATA_W    = 32,
  parameter int                FRAME_LEN = 501,
  parameter logic [DATA_W-1:0] A_START   = '0,
  parameter logic [DATA_W-1:0] A_STEP    = DATA_W'(1),
  parameter logic [DATA_W-1:0] B_VALUE   = DATA_W'(1),
  parameter int                CNT_W     = 16
) (
  input  wire logic             clk_0,
  input  wire logic             rst_n_0,
  input  wire logic             start,
  input  wire logic [CNT_W-1:0] num_frames,
  input  wire logic             stop,
  input  wire logic             rdy_throttle,
  axis_sub_stim_chk_if.master   m_axis_a,
  axis_sub_stim_chk_if.master   m_axis_b,
  axis_sub_stim_chk_if.slave    s_axis_result,
  output logic                  busy,
  output logic                  done,
  output logic      [CNT_W-1:0] beat_cnt,
  output logic      [CNT_W-1:0] err_cnt,
  output logic                  tlast_err
);

  localparam int                 c_IDX_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [c_IDX_W-1:0] c_LAST  = c_IDX_W'(FRAME_LEN - 1);
  // Expected result of beat 0; later beats step by A_STEP (b is constant).
  localparam logic [DATA_W-1:0]  c_EXP0  = A_START - B_VALUE;

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_RUN   = 2'd1;
  localparam logic [1:0] c_DRAIN = 2'd2;

  logic [1:0]         r_state, w_state_nxt;
  logic [CNT_W-1:0]   r_num_frames;
  logic               r_stop, r_toggle;

  logic               r_a_valid, r_b_valid;
  logic [c_IDX_W-1:0] r_a_idx, r_b_idx, r_res_idx;
  logic [CNT_W-1:0]   r_a_frames, r_b_frames, r_res_frames;
  logic [DATA_W-1:0]  r_a_data, r_exp_data;

  logic w_start, w_stop, w_drained;
  logic w_a_fire, w_b_fire, w_res_fire;
  logic w_a_hit, w_b_hit, w_res_last, w_data_bad, w_last_bad;

  // start is only honoured in IDLE; a stop pulse in IDLE is discarded.
  assign w_start    = (r_state == c_IDLE) && start;
  assign w_stop     = r_stop || ((r_state != c_IDLE) && stop);
  assign w_drained  = (r_res_frames == r_a_frames);

  assign w_a_fire   = r_a_valid && m_axis_a.tready;
  assign w_b_fire   = r_b_valid && m_axis_b.tready;
  assign w_res_fire = s_axis_result.tvalid && s_axis_result.tready;

  // Frame limit reached once the frame now closing is counted.
  assign w_a_hit = (r_num_frames != '0) && ((r_a_frames + CNT_W'(1)) == r_num_frames);
  assign w_b_hit = (r_num_frames != '0) && ((r_b_frames + CNT_W'(1)) == r_num_frames);

  assign w_res_last = (r_res_idx == c_LAST);
  assign w_data_bad = (s_axis_result.tdata != r_exp_data);
  assign w_last_bad = (s_axis_result.tlast != w_res_last);

  assign m_axis_a.tdata  = r_a_data;
  assign m_axis_a.tlast  = r_a_valid && (r_a_idx == c_LAST);
  assign m_axis_a.tvalid = r_a_valid;
  assign m_axis_b.tdata  = r_b_valid ? B_VALUE : '0;
  assign m_axis_b.tlast  = r_b_valid && (r_b_idx == c_LAST);
  assign m_axis_b.tvalid = r_b_valid;

  // State register.
  always_ff @(posedge clk_0 or negedge rst_n_0) begin
    if (!rst_n_0) r_state <= c_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next state: RUN until both sources have stopped, DRAIN until all frames return.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_IDLE:  if (start)                   w_state_nxt = c_RUN;
      c_RUN:   if (!r_a_valid && !r_b_valid) w_state_nxt = c_DRAIN;
      c_DRAIN: if (w_drained)               w_state_nxt = c_IDLE;
      default:                              w_state_nxt = c_IDLE;
    endcase
  end

  // State-decoded outputs: busy, done pulse and result ready.
  always_comb begin
    busy                 = 1'b0;
    done                 = 1'b0;
    s_axis_result.tready = 1'b0;
    if (r_state == c_RUN || r_state == c_DRAIN) begin
      busy                 = 1'b1;
      s_axis_result.tready = rdy_throttle ? r_toggle : 1'b1;
    end
    if (r_state == c_DRAIN && w_drained) done = 1'b1;
  end

  // Run controls: frame budget sampled at start, stop latch, ready toggle.
  always_ff @(posedge clk_0 or negedge rst_n_0) begin
    if (!rst_n_0) begin
      r_num_frames <= '0;
      r_stop       <= 1'b0;
      r_toggle     <= 1'b0;
    end else if (r_state == c_IDLE) begin
      r_stop <= 1'b0;
      if (start) begin
        r_num_frames <= num_frames;
        r_toggle     <= 1'b1;
      end
    end else begin
      r_toggle <= ~r_toggle;
      if (stop) r_stop <= 1'b1;
    end
  end

  // Source a: ramp data, framed; stops at the frame limit or a stop at a frame boundary.
  always_ff @(posedge clk_0 or negedge rst_n_0) begin
    if (!rst_n_0) begin
      r_a_valid  <= 1'b0;
      r_a_idx    <= '0;
      r_a_frames <= '0;
      r_a_data   <= '0;
    end else if (r_state == c_IDLE) begin
      if (start) begin
        r_a_valid  <= 1'b1;
        r_a_idx    <= '0;
        r_a_frames <= '0;
        r_a_data   <= A_START;
      end
    end else if (w_a_fire) begin
      if (r_a_idx == c_LAST) begin
        r_a_idx    <= '0;
        r_a_data   <= A_START;
        r_a_frames <= r_a_frames + CNT_W'(1);
        r_a_valid  <= !(w_a_hit || w_stop);
      end else begin
        r_a_idx  <= r_a_idx + c_IDX_W'(1);
        r_a_data <= r_a_data + A_STEP;
      end
    end else if (r_a_valid && w_stop && r_a_idx == '0 && r_a_frames != '0) begin
      // Stop arriving between frames ends the source without opening a new frame.
      r_a_valid <= 1'b0;
    end
  end

  // Source b: constant data with the same framing rules as a, advancing independently.
  always_ff @(posedge clk_0 or negedge rst_n_0) begin
    if (!rst_n_0) begin
      r_b_valid  <= 1'b0;
      r_b_idx    <= '0;
      r_b_frames <= '0;
    end else if (r_state == c_IDLE) begin
      if (start) begin
        r_b_valid  <= 1'b1;
        r_b_idx    <= '0;
        r_b_frames <= '0;
      end
    end else if (w_b_fire) begin
      if (r_b_idx == c_LAST) begin
        r_b_idx    <= '0;
        r_b_frames <= r_b_frames + CNT_W'(1);
        r_b_valid  <= !(w_b_hit || w_stop);
      end else begin
        r_b_idx <= r_b_idx + c_IDX_W'(1);
      end
    end else if (r_b_valid && w_stop && r_b_idx == '0 && r_b_frames != '0) begin
      r_b_valid <= 1'b0;
    end
  end

  // Checker: compare each accepted result to its own index model; never resyncs.
  always_ff @(posedge clk_0 or negedge rst_n_0) begin
    if (!rst_n_0) begin
      r_res_idx    <= '0;
      r_res_frames <= '0;
      r_exp_data   <= '0;
      beat_cnt     <= '0;
      err_cnt      <= '0;
      tlast_err    <= 1'b0;
    end else if (w_start) begin
      r_res_idx    <= '0;
      r_res_frames <= '0;
      r_exp_data   <= c_EXP0;
      beat_cnt     <= '0;
      err_cnt      <= '0;
      tlast_err    <= 1'b0;
    end else if (w_res_fire) begin
      if (beat_cnt != '1) beat_cnt <= beat_cnt + CNT_W'(1);
      if ((w_data_bad || w_last_bad) && err_cnt != '1) err_cnt <= err_cnt + CNT_W'(1);
      if (w_last_bad) tlast_err <= 1'b1;
      if (w_res_last) begin
        r_res_idx    <= '0;
        r_exp_data   <= c_EXP0;
        r_res_frames <= r_res_frames + CNT_W'(1);
      end else begin
        r_res_idx  <= r_res_idx + c_IDX_W'(1);
        r_exp_data <= r_exp_data + A_STEP;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_axis_sub_stim_chk.sv
`default_nettype none
// ============================================================================
//  Module   : tb_axis_sub_stim_chk
//  Purpose  : Directed bench for axis_sub_stim_chk with an ideal subtracter
//             model closing the loop between operand and result streams.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_axis_sub_stim_chk;
  localparam int DATA_W    = 32;
  localparam int FRAME_LEN = 4;
  localparam int CNT_W     = 16;

  logic             clk_0   = 1'b0;
  logic             rst_n_0 = 1'b0;
  logic             start   = 1'b0;
  logic             stop    = 1'b0;
  logic             rdy_throttle = 1'b0;
  logic [CNT_W-1:0] num_frames = '0;
  logic             busy, done, tlast_err;
  logic [CNT_W-1:0] beat_cnt, err_cnt;

  axis_sub_stim_chk_if #(.DATA_W(DATA_W)) a_if ();
  axis_sub_stim_chk_if #(.DATA_W(DATA_W)) b_if ();
  axis_sub_stim_chk_if #(.DATA_W(DATA_W)) r_if ();

  axis_sub_stim_chk #(
    .DATA_W(DATA_W), .FRAME_LEN(FRAME_LEN), .A_START(32'd0), .A_STEP(32'd1),
    .B_VALUE(32'd1), .CNT_W(CNT_W)
  ) dut (
    .clk_0(clk_0), .rst_n_0(rst_n_0), .start(start), .num_frames(num_frames),
    .stop(stop), .rdy_throttle(rdy_throttle),
    .m_axis_a(a_if), .m_axis_b(b_if), .s_axis_result(r_if),
    .busy(busy), .done(done), .beat_cnt(beat_cnt), .err_cnt(err_cnt),
    .tlast_err(tlast_err)
  );

  always #5 clk_0 = ~clk_0;

  // Subtracter model state and bench-driven stream signals
  logic              a_rdy = 1'b1, b_rdy = 1'b1;
  logic              res_valid = 1'b0, res_last = 1'b0;
  logic [DATA_W-1:0] res_data = '0;
  bit                res_taken, corrupt_en;
  int                res_beat;
  logic [DATA_W-1:0] qa[$], qb[$], a_log[$], b_log[$];
  bit                qa_last[$], a_log_last[$];
  int                passed = 0, failed = 0, total = 0;
  int                pulses, n;
  int                bsz;

  assign a_if.tready = a_rdy;
  assign b_if.tready = b_rdy;
  assign r_if.tvalid = res_valid;
  assign r_if.tdata  = res_data;
  assign r_if.tlast  = res_last;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expected);
    total++;
    assert (obs === expected) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expected);
    end
  endtask

  task automatic model_reset();
    qa.delete(); qb.delete(); qa_last.delete();
    a_log.delete(); b_log.delete(); a_log_last.delete();
    res_valid = 1'b0; res_taken = 1'b0; res_beat = 0;
  endtask

  // Record transfers that the coming clock edge will complete.
  task automatic model_capture();
    if (a_if.tvalid && a_if.tready) begin
      qa.push_back(a_if.tdata); qa_last.push_back(a_if.tlast);
      a_log.push_back(a_if.tdata); a_log_last.push_back(a_if.tlast);
    end
    if (b_if.tvalid && b_if.tready) begin
      qb.push_back(b_if.tdata); b_log.push_back(b_if.tdata);
    end
    res_taken = res_valid && r_if.tready;
  endtask

  // Present the next result once the previous one was accepted.
  task automatic model_drive();
    if (!res_valid || res_taken) begin
      if (qa.size() > 0 && qb.size() > 0) begin
        res_data = qa.pop_front() - qb.pop_front();
        res_last = qa_last.pop_front();
        if (corrupt_en && res_beat == 2) res_data = 32'h5;
        if (corrupt_en && res_beat == 3) res_last = 1'b0;
        res_beat++;
        res_valid = 1'b1;
      end else begin
        res_valid = 1'b0;
      end
    end
    res_taken = 1'b0;
  endtask

  task automatic tick();
    #1;
    model_capture();
    @(posedge clk_0);
    #1;
    model_drive();
  endtask

  task automatic start_run(input logic [CNT_W-1:0] nf);
    model_reset();
    num_frames = nf;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(output int np);
    np = 0;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (done) np++;
      if (!busy) break;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Power-on reset state
    repeat (3) tick();
    check("rst_a_tvalid", a_if.tvalid, 0);
    check("rst_b_tvalid", b_if.tvalid, 0);
    check("rst_res_tready", r_if.tready, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_beat_cnt", beat_cnt, 0);
    check("rst_err_cnt", err_cnt, 0);
    check("rst_tlast_err", tlast_err, 0);
    rst_n_0 = 1'b1;
    tick();

    // Two clean frames through the ideal subtracter
    start_run(16'd2);
    check("t2_a_tvalid_after_start", a_if.tvalid, 1);
    check("t2_a_tdata_first", a_if.tdata, 0);
    check("t2_busy", busy, 1);
    check("t2_res_tready", r_if.tready, 1);
    wait_done(pulses);
    check("t2_done_pulses", pulses, 1);
    check("t2_busy_fell", busy, 0);
    check("t2_beat_cnt", beat_cnt, 8);
    check("t2_err_cnt", err_cnt, 0);
    check("t2_tlast_err", tlast_err, 0);
    check("t2_a_beats", a_log.size(), 8);
    check("t2_b_beats", b_log.size(), 8);
    for (int i = 0; i < 8 && i < a_log.size() && i < b_log.size(); i++) begin
      check($sformatf("t2_a_data[%0d]", i), a_log[i], i % 4);
      check($sformatf("t2_a_last[%0d]", i), a_log_last[i], (i % 4) == 3);
      check($sformatf("t2_b_data[%0d]", i), b_log[i], 1);
    end
    check("t2_a_tvalid_idle", a_if.tvalid, 0);
    tick();
    check("t2_done_single", done, 0);

    // a stalled for 5 cycles at idx2 while b keeps streaming
    start_run(16'd2);
    n = 0;
    while (!(a_if.tvalid && a_if.tdata == 2) && n < 20) begin
      tick();
      n++;
    end
    check("t3_reach_idx2", a_if.tdata, 2);
    bsz = b_log.size();
    a_rdy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("t3_hold_valid[%0d]", i), a_if.tvalid, 1);
      check($sformatf("t3_hold_data[%0d]", i), a_if.tdata, 2);
      check($sformatf("t3_hold_last[%0d]", i), a_if.tlast, 0);
    end
    check("t3_b_streamed", b_log.size() - bsz, 5);
    a_rdy = 1'b1;
    wait_done(pulses);
    check("t3_done_pulses", pulses, 1);
    check("t3_beat_cnt", beat_cnt, 8);
    check("t3_err_cnt", err_cnt, 0);

    // Result beat 2 data corrupted, beat 3 tlast cleared
    corrupt_en = 1'b1;
    start_run(16'd2);
    wait_done(pulses);
    corrupt_en = 1'b0;
    check("t4_done_pulses", pulses, 1);
    check("t4_beat_cnt", beat_cnt, 8);
    check("t4_err_cnt", err_cnt, 2);
    check("t4_tlast_err", tlast_err, 1);

    // Endless run stopped at a idx1: sources finish the frame then drain
    start_run(16'd0);
    n = 0;
    while (!(a_if.tvalid && a_if.tdata == 1) && n < 20) begin
      tick();
      n++;
    end
    check("t5_reach_idx1", a_if.tdata, 1);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    wait_done(pulses);
    check("t5_done_pulses", pulses, 1);
    check("t5_a_beats", a_log.size(), 4);
    check("t5_b_beats", b_log.size(), 4);
    if (a_log.size() == 4) begin
      check("t5_a_last_data", a_log[3], 3);
      check("t5_a_last_flag", a_log_last[3], 1);
    end
    check("t5_beat_cnt", beat_cnt, 4);
    check("t5_err_cnt", err_cnt, 0);
    check("t5_a_tvalid", a_if.tvalid, 0);
    check("t5_b_tvalid", b_if.tvalid, 0);

    // Throttled result ready: 1,0,1,0 from the first busy cycle
    rdy_throttle = 1'b1;
    start_run(16'd2);
    check("t6_tready[0]", r_if.tready, 1);
    tick();
    check("t6_tready[1]", r_if.tready, 0);
    tick();
    check("t6_tready[2]", r_if.tready, 1);
    tick();
    check("t6_tready[3]", r_if.tready, 0);
    wait_done(pulses);
    rdy_throttle = 1'b0;
    check("t6_done_pulses", pulses, 1);
    check("t6_beat_cnt", beat_cnt, 8);
    check("t6_err_cnt", err_cnt, 0);

    // Stray result offered while idle is neither accepted nor counted
    res_data  = 32'hDEAD_BEEF;
    res_last  = 1'b0;
    res_valid = 1'b1;
    repeat (3) tick();
    check("idle_res_tready", r_if.tready, 0);
    check("idle_beat_cnt", beat_cnt, 8);
    check("idle_err_cnt", err_cnt, 0);
    res_valid = 1'b0;

    // Reset in the middle of a run aborts everything immediately
    start_run(16'd0);
    repeat (6) tick();
    check("t1_busy_before", busy, 1);
    rst_n_0 = 1'b0;
    #1;
    check("t1_a_tvalid", a_if.tvalid, 0);
    check("t1_b_tvalid", b_if.tvalid, 0);
    check("t1_res_tready", r_if.tready, 0);
    check("t1_busy", busy, 0);
    check("t1_done", done, 0);
    check("t1_beat_cnt", beat_cnt, 0);
    check("t1_err_cnt", err_cnt, 0);
    check("t1_tlast_err", tlast_err, 0);
    model_reset();
    repeat (2) tick();
    rst_n_0 = 1'b1;
    tick();
    check("t1_idle_after", busy, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
`default_nettype wire
